button_debouncer: RTL and testbench

Debounces one raw push-button input, qualifying every change against the sampling strobe from the upstream tick `pulse_generator`. It produces a clean level plus one-cycle press, release and auto-repeat pulses. It sits between the board button pins and the etch-a-sketch cursor logic, which consumes the pulses as single-step move commands.

---
 rtl/button_debouncer.sv | 150 +++++++++++++++
 tb/tb_button_debouncer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Tick-qualified push-button debouncer with press/release pulses
//               and hold-to-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int BOUNCE_TICKS = 4,
    parameter int HOLD_TICKS   = 32,
    parameter int REPEAT_TICKS = 8,
    parameter int CW           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic button,
    output logic debounced,
    output logic pressed,
    output logic released,
    output logic repeat_pulse
);

    localparam logic [CW-1:0] c_one         = CW'(1);
    localparam logic [CW-1:0] c_bounce_last = CW'(BOUNCE_TICKS - 1);
    localparam logic [CW-1:0] c_hold_last   = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] c_repeat_last = CW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        S_LOW        = 2'd0,
        S_MAYBE_HIGH = 2'd1,
        S_HIGH       = 2'd2,
        S_MAYBE_LOW  = 2'd3
    } state_t;

    logic          r_btn_meta;
    logic          r_btn_s;
    state_t        r_state;
    logic [CW-1:0] r_bcnt;
    logic [CW-1:0] r_hcnt;
    logic          r_first_done;

    state_t        w_state_nxt;
    logic [CW-1:0] w_bcnt_nxt;
    logic [CW-1:0] w_hcnt_nxt;
    logic          w_first_nxt;
    logic          w_pressed_nxt;
    logic          w_released_nxt;
    logic          w_repeat_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_btn_meta <= button;
            r_btn_s    <= r_btn_meta;
        end
    end

    // A disagreeing btn_s always wins over a coincident tick in the MAYBE states.
    always_comb begin
        w_state_nxt    = r_state;
        w_bcnt_nxt     = r_bcnt;
        w_hcnt_nxt     = r_hcnt;
        w_first_nxt    = r_first_done;
        w_pressed_nxt  = 1'b0;
        w_released_nxt = 1'b0;
        w_repeat_nxt   = 1'b0;
        case (r_state)
            S_LOW: begin
                if (r_btn_s) begin
                    w_state_nxt = S_MAYBE_HIGH;
                    w_bcnt_nxt  = '0;
                end
            end
            S_MAYBE_HIGH: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_LOW;
                end else if (tick) begin
                    if (r_bcnt == c_bounce_last) begin
                        w_state_nxt   = S_HIGH;
                        w_pressed_nxt = 1'b1;
                        w_hcnt_nxt    = '0;
                        w_first_nxt   = 1'b0;
                    end else begin
                        w_bcnt_nxt = r_bcnt + c_one;
                    end
                end
            end
            S_HIGH: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_MAYBE_LOW;
                    w_bcnt_nxt  = '0;
                end else if (tick) begin
                    if (!r_first_done && (r_hcnt == c_hold_last)) begin
                        w_repeat_nxt = 1'b1;
                        w_hcnt_nxt   = '0;
                        w_first_nxt  = 1'b1;
                    end else if (r_first_done && (r_hcnt == c_repeat_last)) begin
                        w_repeat_nxt = 1'b1;
                        w_hcnt_nxt   = '0;
                    end else begin
                        w_hcnt_nxt = r_hcnt + c_one;
                    end
                end
            end
            S_MAYBE_LOW: begin
                // hcnt/first_done untouched so a glitch only pauses the repeat cadence
                if (r_btn_s) begin
                    w_state_nxt = S_HIGH;
                end else if (tick) begin
                    if (r_bcnt == c_bounce_last) begin
                        w_state_nxt    = S_LOW;
                        w_released_nxt = 1'b1;
                    end else begin
                        w_bcnt_nxt = r_bcnt + c_one;
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOW;
            r_bcnt       <= '0;
            r_hcnt       <= '0;
            r_first_done <= 1'b0;
            debounced    <= 1'b0;
            pressed      <= 1'b0;
            released     <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_first_done <= w_first_nxt;
            debounced    <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_MAYBE_LOW);
            pressed      <= w_pressed_nxt;
            released     <= w_released_nxt;
            repeat_pulse <= w_repeat_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Randomized and directed bench for button_debouncer against a
//               tick-counting behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int B  = 4;
    localparam int H  = 32;
    localparam int R  = 8;
    localparam int CW = 8;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic tick   = 1'b0;
    logic button = 1'b0;
    logic debounced, pressed, released, repeat_pulse;

    always #5 clk = ~clk;

    button_debouncer #(
        .BOUNCE_TICKS(B),
        .HOLD_TICKS  (H),
        .REPEAT_TICKS(R),
        .CW          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .button      (button),
        .debounced   (debounced),
        .pressed     (pressed),
        .released    (released),
        .repeat_pulse(repeat_pulse)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a change is accepted once B ticks have passed since
    // btn_s last changed (the change edge itself excluded); repeats fire when
    // the count of uninterrupted held ticks reaches H, H+R, H+2R, ...
    bit m_sync1 = 0, m_sync2 = 0, m_prev = 0, m_level = 0;
    int m_since = 0, m_held = 0;
    bit e_deb = 0, e_p = 0, e_r = 0, e_rep = 0;
    bit model_valid = 0;

    always @(posedge clk) begin
        bit s;
        bit t;
        s = m_sync2;
        t = tick;
        if (rst) begin
            m_sync1 = 0; m_sync2 = 0; m_prev = 0; m_level = 0;
            m_since = 0; m_held = 0;
            e_deb = 0; e_p = 0; e_r = 0; e_rep = 0;
            model_valid = 1;
        end else begin
            e_p = 0; e_r = 0; e_rep = 0;
            if (s != m_prev) m_since = 0;
            else if (t) m_since++;
            if (m_level && s && m_prev && t) begin
                m_held++;
                if (m_held >= H && ((m_held - H) % R) == 0) e_rep = 1;
            end
            if (s != m_level && t && m_since == B) begin
                m_level = s;
                if (s) begin
                    e_p    = 1;
                    m_held = 0;
                end else begin
                    e_r = 1;
                end
            end
            m_prev  = s;
            m_sync2 = m_sync1;
            m_sync1 = button;
            e_deb   = m_level;
        end
    end

    int  tph = 0;
    bit  rand_tick = 0;
    int  n_ticks = 0;
    int  cnt_p = 0, cnt_r = 0, cnt_rep = 0, cnt_ovl = 0, cnt_pnd = 0;
    int  cnt_deb_hi = 0, cnt_deb_lo = 0;

    // One cycle: compare the outputs of the edge just passed, then set up the next tick.
    task automatic step();
        @(negedge clk);
        if (model_valid)
            check("outputs{deb,p,r,rep}", {28'd0, debounced, pressed, released, repeat_pulse},
                  {28'd0, e_deb, e_p, e_r, e_rep});
        if (tick) n_ticks++;
        if (pressed === 1'b1) cnt_p++;
        if (released === 1'b1) cnt_r++;
        if (repeat_pulse === 1'b1) cnt_rep++;
        if ((32'(pressed) + 32'(released) + 32'(repeat_pulse)) > 1) cnt_ovl++;
        if (pressed === 1'b1 && debounced !== 1'b1) cnt_pnd++;
        if (debounced === 1'b1) cnt_deb_hi++;
        else cnt_deb_lo++;
        tph  = (tph + 1) % 4;
        tick = rand_tick ? ($urandom_range(0, 2) == 0) : (tph == 3);
    endtask

    task automatic wait_pressed(input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (pressed !== 1'b1 && k < 200);
        if (pressed !== 1'b1) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_released(input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (released !== 1'b1 && k < 200);
        if (released !== 1'b1) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int s_p, s_r, s_rep, s_ovl, s_pnd, s_hi, s_lo, s_t, first_rep, k, runleft;

        // Reset held 3 cycles with the button pressed
        rst = 1; button = 1;
        repeat (3) begin
            step();
            check("reset_outputs_zero", {28'd0, debounced, pressed, released, repeat_pulse}, 0);
        end
        rst = 0;
        s_t = n_ticks;
        wait_pressed("reset_press");
        check("reset_press_tick_count_in_4_5",
              ((n_ticks - s_t) >= 4 && (n_ticks - s_t) <= 5) ? 1 : 0, 1);
        button = 0;
        wait_released("reset_release");
        repeat (20) step();

        // Clean press / release
        s_p = cnt_p; s_r = cnt_r; s_pnd = cnt_pnd;
        button = 1;
        repeat (40) step();
        button = 0;
        repeat (40) step();
        check("clean_pressed_count", cnt_p - s_p, 1);
        check("clean_released_count", cnt_r - s_r, 1);
        check("clean_pressed_without_debounced", cnt_pnd - s_pnd, 0);

        // Bounce: toggle every 6 clocks
        s_p = cnt_p; s_hi = cnt_deb_hi;
        for (int i = 0; i < 10; i++) begin
            button = ~button;
            repeat (6) step();
        end
        button = 0;
        repeat (20) step();
        check("bounce_pressed_count", cnt_p - s_p, 0);
        check("bounce_debounced_high_cycles", cnt_deb_hi - s_hi, 0);

        // Auto-repeat: hold 210 ticks after the press
        button = 1;
        wait_pressed("repeat_press");
        s_rep = cnt_rep; s_ovl = cnt_ovl; s_t = n_ticks; first_rep = -1;
        while ((n_ticks - s_t) < 210) begin
            step();
            if (repeat_pulse === 1'b1 && first_rep < 0) first_rep = n_ticks - s_t;
        end
        button = 0;
        wait_released("repeat_release");
        check("repeat_first_after_ticks", first_rep, 32);
        check("repeat_pulse_count", cnt_rep - s_rep, 23);
        check("repeat_pulse_overlap", cnt_ovl - s_ovl, 0);
        s_rep = cnt_rep;
        repeat (50) step();
        check("repeat_after_release", cnt_rep - s_rep, 0);

        // Release glitch: btn_s low across exactly 2 ticks
        button = 1;
        wait_pressed("glitch_press");
        s_r = cnt_r; s_lo = cnt_deb_lo; s_t = n_ticks; first_rep = -1;
        while ((n_ticks - s_t) < 20) step();
        k = 0;
        while (tick !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        button = 0;
        repeat (8) step();
        button = 1;
        k = 0;
        while (first_rep < 0 && k < 400) begin
            step();
            if (repeat_pulse === 1'b1) first_rep = n_ticks - s_t;
            k++;
        end
        check("glitch_first_repeat_ticks", first_rep, 34);
        check("glitch_released_count", cnt_r - s_r, 0);
        check("glitch_debounced_low_cycles", cnt_deb_lo - s_lo, 0);
        button = 0;
        wait_released("glitch_release");
        repeat (20) step();

        // Race: btn_s drops on the tick that would have been the 4th
        k = 0;
        while (tph != 1 && k < 8) begin
            step();
            k++;
        end
        s_p = cnt_p;
        button = 1;
        repeat (16) step();
        button = 0;
        repeat (40) step();
        check("race_no_press", cnt_p - s_p, 0);

        // Reset mid-hold
        button = 1;
        wait_pressed("midreset_press");
        repeat (10) step();
        rst = 1;
        step();
        check("midreset_outputs_zero", {28'd0, debounced, pressed, released, repeat_pulse}, 0);
        repeat (2) step();
        rst = 0; button = 0;
        s_r = cnt_r;
        repeat (40) step();
        check("midreset_no_release", cnt_r - s_r, 0);

        // Randomized ticks, button runs and occasional resets
        rand_tick = 1;
        s_ovl = cnt_ovl;
        runleft = 0;
        for (int i = 0; i < 6000; i++) begin
            if (runleft == 0) begin
                button  = $urandom_range(0, 1);
                runleft = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 400) : $urandom_range(1, 12);
            end
            runleft--;
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 0;
        repeat (5) step();
        check("random_pulse_overlap", cnt_ovl - s_ovl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
